reg_file_16x16: RTL

- 16-entry x 16-bit register file with one synchronous write port and two read ports.
- Sits directly downstream of the 4-to-16 write-destination decoder and consumes its one-hot output as the per-register write select.
- Adds registered reads with write-first bypass, and one-hot checking on the select.
- Adds a sequenced clear engine that zeroes all registers, one per cycle.

---
 rtl/reg_file_16x16_pkg.sv | 29 ++
 rtl/reg_file_16x16_if.sv | 28 ++
 rtl/reg_file_clear_fsm.sv | 60 ++++++
 rtl/reg_file_16x16.sv | 58 +++++
 4 files changed

// File: rtl/reg_file_16x16_pkg.sv
// Shared constants, clear-engine state encoding and one-hot helpers for the
// 16x16 register file and the upstream 4-to-16 decoder bench.
package reg_file_16x16_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  function automatic logic is_onehot(input logic [NUM_REGS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Only meaningful when is_onehot(v) holds; ORs indices of all set bits.
  function automatic logic [ADDR_W-1:0] onehot_to_idx(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (v[i]) idx = idx | ADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_file_16x16_if.sv
// Write/read/clear bus of the 16x16 register file.
interface reg_file_16x16_if;
  import reg_file_16x16_pkg::*;

  logic                wr_en;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;
  logic                sel_err;
  logic                wr_drop;

  modport master (
    output wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input  rd_data_a, rd_data_b, clr_busy, clr_done, sel_err, wr_drop
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, clr_busy, clr_done, sel_err, wr_drop
  );

endinterface

// File: rtl/reg_file_clear_fsm.sv
// Clear sequencer: walks the register index from 0 to NUM_REGS-1, one per
// cycle, then pulses done for a single cycle.
module reg_file_clear_fsm
  import reg_file_16x16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [1:0] IDLE  = CLR_IDLE;
  localparam logic [1:0] CLEAR = CLR_CLEAR;
  localparam logic [1:0] DONE  = CLR_DONE;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (clr_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (cnt == ADDR_W'(NUM_REGS - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_busy <= (state_nxt == CLEAR);
      clr_done <= (state_nxt == DONE);
    end
  end

  assign clr_en  = (state == CLEAR);
  assign clr_idx = cnt;

endmodule

// File: rtl/reg_file_16x16.sv
// 16x16 register file: one-hot selected write port, two registered read
// ports with write-first bypass, and a sequenced clear engine.
module reg_file_16x16
  import reg_file_16x16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  reg_file_16x16_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_a_p1, rd_b_p1;
  logic              sel_err_p1, wr_drop_p1;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              sel_ok, wr_ok, wr_commit;
  logic [ADDR_W-1:0] wr_idx;

  reg_file_clear_fsm u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .clr_busy (bus.clr_busy),
    .clr_done (bus.clr_done),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  assign sel_ok    = is_onehot(bus.wr_sel);
  assign wr_ok     = bus.wr_en && sel_ok;
  assign wr_commit = wr_ok && !clr_en;
  assign wr_idx    = onehot_to_idx(bus.wr_sel);

  // Stage p0 -> p1: storage update, registered reads and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_a_p1    <= '0;
      rd_b_p1    <= '0;
      sel_err_p1 <= 1'b0;
      wr_drop_p1 <= 1'b0;
    end else begin
      if (wr_commit) regs[wr_idx] <= bus.wr_data;
      if (clr_en)    regs[clr_idx] <= '0;
      rd_a_p1    <= (wr_commit && wr_idx == bus.rd_addr_a) ? bus.wr_data : regs[bus.rd_addr_a];
      rd_b_p1    <= (wr_commit && wr_idx == bus.rd_addr_b) ? bus.wr_data : regs[bus.rd_addr_b];
      sel_err_p1 <= bus.wr_en && !sel_ok;
      wr_drop_p1 <= wr_ok && clr_en;
    end
  end

  assign bus.rd_data_a = rd_a_p1;
  assign bus.rd_data_b = rd_b_p1;
  assign bus.sel_err   = sel_err_p1;
  assign bus.wr_drop   = wr_drop_p1;

endmodule
